// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state enum and widths for the I2C slave receiver.
// Build option I2C_GLITCH_FILTER_EN lives in i2c_line_filter.
`timescale 1ns/1ps
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam logic [2:0] BIT_LAST = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT_STOP
  } state_e;
endpackage

// File: rtl/i2c_slave_rx_if.sv
// i2c_slave_rx_if: received-byte valid/ready handshake.
// master = byte producer (receiver), slave = consumer.
`timescale 1ns/1ps
interface i2c_slave_rx_if;
  import i2c_pkg::*;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchroniser, sample-rate filter, edge flags.
// I2C_GLITCH_FILTER_EN adds a 3-sample majority vote.
`timescale 1ns/1ps
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn,
  input  logic sample_en,
  input  logic line_i,
  output logic cur_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic filt_q, filt_d;
  logic sync_s;

  // metastability chain, clocked every cycle
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;

  // majority of the two previous samples and this one
  always_comb begin
    hist_d = hist_q;
    filt_d = filt_q;
    if (sample_en) begin
      hist_d = {hist_q[0], sync_s};
      filt_d = (hist_q[1] & hist_q[0]) |
               (hist_q[1] & sync_s) |
               (hist_q[0] & sync_s);
    end
  end

  // sample history register
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end
`else
  // plain capture of the synchronised line
  always_comb begin
    filt_d = filt_q;
    if (sample_en) filt_d = sync_s;
  end
`endif

  // filtered line value, idle-high
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) filt_q <= 1'b1;
    else       filt_q <= filt_d;
  end

  assign cur_o  = filt_d;
  assign rise_o = sample_en & filt_d & ~filt_q;
  assign fall_o = sample_en & ~filt_d & filt_q;
endmodule

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C slave receive front-end.
// Build option I2C_GLITCH_FILTER_EN (majority filter on SCL/SDA).
`timescale 1ns/1ps
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h42,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rstn,
  input  logic           sample_en,
  input  logic           scl_i,
  input  logic           sda_i,
  output logic           sda_oe,
  output logic           start_det,
  output logic           stop_det,
  output logic           addr_hit,
  output logic           busy,
  output logic           rx_ovf,
  i2c_slave_rx_if.master rx_if
);
  localparam int BW = I2C_BYTE_W;

  logic scl_cur, scl_rise, scl_fall;
  logic sda_cur, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [BW-1:0]   shift_q, shift_d;
  logic [BW-1:0]   data_q, data_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            oe_q, oe_d;
  logic            valid_q, valid_d;
  logic            hit_q, hit_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic            stop_q, stop_d;
  logic            ovf_q, ovf_d;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk_i(clk_i), .rstn(rstn), .sample_en(sample_en),
    .line_i(scl_i), .cur_o(scl_cur),
    .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk_i(clk_i), .rstn(rstn), .sample_en(sample_en),
    .line_i(sda_i), .cur_o(sda_cur),
    .rise_o(sda_rise), .fall_o(sda_fall)
  );

  // SCL high in both previous and current sample
  assign start_ev = sda_fall & scl_cur & ~scl_rise;
  assign stop_ev  = sda_rise & scl_cur & ~scl_rise;

  // protocol next-state: bus conditions win over bit events
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = done_q;
    ack_d   = ack_q;
    oe_d    = oe_q;
    valid_d = valid_q;
    hit_d   = hit_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    ovf_d   = 1'b0;
    if (valid_q && rx_if.rx_ready) valid_d = 1'b0;
    if (start_ev) begin
      state_d = ADDR;
      cnt_d   = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
      hit_d   = 1'b0;
      start_d = 1'b1;
    end else if (stop_ev) begin
      state_d = IDLE;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      hit_d   = 1'b0;
      oe_d    = 1'b0;
      stop_d  = 1'b1;
    end else if (sample_en) begin
      unique case (state_q)
        ADDR, DATA: begin
          if (scl_rise && !done_q) begin
            shift_d = {shift_q[BW-2:0], sda_cur};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == BIT_LAST) begin
              done_d = 1'b1;
              if (state_q == ADDR) begin
                ack_d = (shift_d[BW-1:1] == SLAVE_ADDR)
                        && !shift_d[0];
              end else if (!valid_q) begin
                data_d  = shift_d;
                valid_d = 1'b1;
                ack_d   = 1'b1;
              end else begin
                ovf_d = 1'b1;
                ack_d = 1'b0;
              end
            end
          end else if (scl_fall && done_q) begin
            done_d  = 1'b0;
            oe_d    = ack_q;
            state_d = (state_q == ADDR) ? ADDR_ACK
                                        : DATA_ACK;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = ack_q ? DATA : WAIT_STOP;
            if (state_q == ADDR_ACK) hit_d = ack_q;
          end
        end
        default: ;
      endcase
    end
  end

  // protocol state and output registers
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sda_oe         = oe_q;
  assign start_det      = start_q;
  assign stop_det       = stop_q;
  assign addr_hit       = hit_q;
  assign busy           = busy_q;
  assign rx_ovf         = ovf_q;
  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: bus-level I2C master model driving random
// writes, checked against a transaction-level expectation model.
`timescale 1ns/1ps
module tb_i2c_slave_rx;
  localparam int SP = 100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sample_en = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic scl_i, sda_i, sda_oe;
  logic start_det, stop_det, addr_hit, busy, rx_ovf;
  int   se_cnt = 0;

  int checks = 0;
  int errors = 0;

  int n_start = 0, n_stop = 0, n_ovf = 0;
  int n_vrise = 0, n_oe = 0;
  logic oe_prev = 1'b0, v_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] data_q[$];

  i2c_slave_rx_if rx_if();

  i2c_slave_rx dut (
    .clk_i(clk),
    .rstn(rstn),
    .sample_en(sample_en),
    .scl_i(scl_i),
    .sda_i(sda_i),
    .sda_oe(sda_oe),
    .start_det(start_det),
    .stop_det(stop_det),
    .addr_hit(addr_hit),
    .busy(busy),
    .rx_ovf(rx_ovf),
    .rx_if(rx_if)
  );

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    se_cnt    <= (se_cnt == 9) ? 0 : se_cnt + 1;
    sample_en <= (se_cnt == 9);
  end

  always @(negedge clk) begin
    if (start_det === 1'b1) n_start++;
    if (stop_det === 1'b1) n_stop++;
    if (rx_ovf === 1'b1) n_ovf++;
    if (rx_if.rx_valid === 1'b1 && v_prev !== 1'b1) n_vrise++;
    if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1)
      got_q.push_back(rx_if.rx_data);
    if (sda_oe === 1'b1 && oe_prev !== 1'b1) n_oe++;
    if (sda_oe !== oe_prev) begin
      checks++;
      if (m_scl !== 1'b0) begin
        errors++;
        $display("FAIL oe_while_scl_high scl=%0b exp 0", m_scl);
      end
    end
    oe_prev = sda_oe;
    v_prev  = rx_if.rx_valid;
  end

  task automatic wait_s(input int n);
    #(SP * n);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_s(2);
    m_scl = 1'b1; wait_s(4);
    m_sda = 1'b0; wait_s(4);
    m_scl = 1'b0; wait_s(2);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_s(2);
    m_scl = 1'b1; wait_s(4);
    m_sda = 1'b1; wait_s(4);
  endtask

  task automatic bus_bit(input logic b, input bit gl);
    m_sda = b; wait_s(4);
    m_scl = 1'b1;
    if (gl) begin
      wait_s(2);
      m_scl = 1'b0; wait_s(1);
      m_scl = 1'b1; wait_s(2);
    end else begin
      wait_s(4);
    end
    m_scl = 1'b0; wait_s(2);
  endtask

  task automatic bus_ack(output logic a);
    m_sda = 1'b1; wait_s(4);
    m_scl = 1'b1; wait_s(2);
    a = (sda_i === 1'b0);
    wait_s(2);
    m_scl = 1'b0; wait_s(3);
  endtask

  task automatic bus_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) bus_bit(b[i], 1'b0);
    bus_ack(a);
  endtask

  // one write transfer; expectations from the protocol rules
  task automatic run_xfer(input logic [7:0] ab, input bit rdy);
    logic a, exp_a, live, pend;
    logic [7:0] exp_q[$];
    int s0, p0, v0, o0, ovf_exp;
    rx_if.rx_ready = rdy;
    got_q.delete();
    s0 = n_start; p0 = n_stop; v0 = n_vrise; o0 = n_ovf;
    ovf_exp = 0;
    bus_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %0b exp 1", busy);
    end
    exp_a = (ab[7:1] == 7'h42) && (ab[0] == 1'b0);
    bus_byte(ab, a);
    checks++;
    if (a !== exp_a) begin
      errors++;
      $display("FAIL addr_ack ab=%02h got %0b exp %0b",
               ab, a, exp_a);
    end
    checks++;
    if (addr_hit !== exp_a) begin
      errors++;
      $display("FAIL addr_hit ab=%02h got %0b exp %0b",
               ab, addr_hit, exp_a);
    end
    live = exp_a;
    pend = 1'b0;
    foreach (data_q[i]) begin
      bus_byte(data_q[i], a);
      if (!live) begin
        exp_a = 1'b0;
      end else if (pend) begin
        exp_a = 1'b0;
        ovf_exp++;
        live = 1'b0;
      end else begin
        exp_a = 1'b1;
        exp_q.push_back(data_q[i]);
        pend = !rdy;
      end
      checks++;
      if (a !== exp_a) begin
        errors++;
        $display("FAIL data_ack #%0d got %0b exp %0b",
                 i, a, exp_a);
      end
    end
    bus_stop();
    checks++;
    if ({busy, addr_hit} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_stop busy/hit got %02b exp 00",
               {busy, addr_hit});
    end
    checks++;
    if (n_start - s0 != 1 || n_stop - p0 != 1) begin
      errors++;
      $display("FAIL det_pulses start=%0d stop=%0d exp 1 1",
               n_start - s0, n_stop - p0);
    end
    checks++;
    if (n_ovf - o0 != ovf_exp) begin
      errors++;
      $display("FAIL ovf_pulses got %0d exp %0d",
               n_ovf - o0, ovf_exp);
    end
    checks++;
    if (n_vrise - v0 != exp_q.size()) begin
      errors++;
      $display("FAIL valid_pulses got %0d exp %0d",
               n_vrise - v0, exp_q.size());
    end
    if (rdy) begin
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rx_count got %0d exp %0d",
                 got_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rx_data #%0d got %02h exp %02h",
                     i, got_q[i], exp_q[i]);
          end
        end
      end
    end else if (exp_q.size() > 0) begin
      checks++;
      if (rx_if.rx_valid !== 1'b1 ||
          rx_if.rx_data !== exp_q[0]) begin
        errors++;
        $display("FAIL held_byte v=%0b d=%02h exp 1 %02h",
                 rx_if.rx_valid, rx_if.rx_data, exp_q[0]);
      end
      @(posedge clk); #1;
      rx_if.rx_ready = 1'b1;
      @(posedge clk); #1;
      rx_if.rx_ready = 1'b0;
      checks++;
      if (rx_if.rx_valid !== 1'b0 || got_q.size() != 1) begin
        errors++;
        $display("FAIL drain v=%0b n=%0d exp 0 1",
                 rx_if.rx_valid, got_q.size());
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({sda_oe, start_det, stop_det, addr_hit, busy, rx_ovf,
         rx_if.rx_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %07b exp 0",
               {sda_oe, start_det, stop_det, addr_hit, busy,
                rx_ovf, rx_if.rx_valid});
    end
    checks++;
    if (rx_if.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %02h exp 00", rx_if.rx_data);
    end
    rstn = 1'b1;
    wait_s(3);
    checks++;
    if ({busy, rx_if.rx_valid, sda_oe} !== 3'b0) begin
      errors++;
      $display("FAIL post_reset got %03b exp 0",
               {busy, rx_if.rx_valid, sda_oe});
    end
  endtask

  task automatic test_write();
    data_q = '{8'hA5};
    run_xfer(8'h84, 1'b1);
  endtask

  task automatic test_bad_addr();
    int oe0;
    oe0 = n_oe;
    data_q = '{8'h5A, 8'hC3};
    run_xfer(8'h86, 1'b1);
    checks++;
    if (n_oe != oe0) begin
      errors++;
      $display("FAIL bad_addr_oe got %0d exp 0", n_oe - oe0);
    end
  endtask

  task automatic test_read();
    data_q = '{8'h77};
    run_xfer(8'h85, 1'b1);
  endtask

  task automatic test_overflow();
    data_q = '{8'h11, 8'h22};
    run_xfer(8'h84, 1'b0);
  endtask

  task automatic test_restart();
    logic a;
    int s0;
    rx_if.rx_ready = 1'b1;
    got_q.delete();
    s0 = n_start;
    bus_start();
    bus_byte(8'h84, a);
    checks++;
    if (a !== 1'b1) begin
      errors++;
      $display("FAIL rs_first_ack got %0b exp 1", a);
    end
    for (int i = 0; i < 4; i++) bus_bit(1'b1, 1'b0);
    bus_start();
    checks++;
    if (n_start - s0 != 2 || busy !== 1'b1 ||
        addr_hit !== 1'b0) begin
      errors++;
      $display("FAIL rs_start n=%0d busy=%0b hit=%0b exp 2 1 0",
               n_start - s0, busy, addr_hit);
    end
    bus_byte(8'h84, a);
    checks++;
    if (a !== 1'b1) begin
      errors++;
      $display("FAIL rs_readdr_ack got %0b exp 1", a);
    end
    bus_byte(8'h3C, a);
    bus_stop();
    checks++;
    if (a !== 1'b1 || got_q.size() != 1 ||
        got_q[0] !== 8'h3C) begin
      errors++;
      $display("FAIL rs_data ack=%0b n=%0d d=%02h exp 1 1 3c",
               a, got_q.size(), got_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    int v0;
    rx_if.rx_ready = 1'b1;
    v0 = n_vrise;
    bus_start();
    bus_byte(8'h84, a);
    for (int i = 0; i < 4; i++) bus_bit(i[0], 1'b0);
    rstn = 1'b0;
    #3;
    checks++;
    if ({sda_oe, busy, addr_hit, rx_if.rx_valid} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset got %04b exp 0",
               {sda_oe, busy, addr_hit, rx_if.rx_valid});
    end
    #27;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) bus_bit(1'b1, 1'b0);
    bus_ack(a);
    checks++;
    if (a !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ack ack=%0b busy=%0b exp 0 0",
               a, busy);
    end
    bus_stop();
    checks++;
    if (n_vrise != v0 || addr_hit !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_rx n=%0d hit=%0b exp 0 0",
               n_vrise - v0, addr_hit);
    end
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic a;
    logic [7:0] b;
    rx_if.rx_ready = 1'b1;
    got_q.delete();
    b = 8'h5A;
    bus_start();
    bus_byte(8'h84, a);
    for (int i = 7; i >= 0; i--) bus_bit(b[i], i == 4);
    bus_ack(a);
    bus_stop();
    checks++;
    if (a !== 1'b1 || got_q.size() != 1 ||
        got_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL glitch ack=%0b n=%0d d=%02h exp 1 1 5a",
               a, got_q.size(), got_q[0]);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] ab;
    bit rdy;
    int n;
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 3))
        0: ab = 8'h84;
        1: ab = 8'h85;
        2: ab = 8'($urandom);
        default: ab = 8'h84;
      endcase
      n = int'($urandom_range(0, 3));
      data_q.delete();
      for (int k = 0; k < n; k++) data_q.push_back(8'($urandom));
      rdy = 1'($urandom);
      run_xfer(ab, rdy);
    end
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_write();
    test_bad_addr();
    test_read();
    test_overflow();
    test_restart();
    test_reset_mid();
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- I2C slave receive front-end, downstream of the clock divider; consumes its 1 MHz sampling rate as a one-cycle strobe (sample_en) in the clk_i domain.
- Oversamples SCL/SDA, detects START/STOP, matches the 7-bit address, shifts in write bytes, drives ACK/NACK open-drain on SDA, and hands bytes to the register file over a valid/ready handshake.
- Write transfers only; read requests are NACKed.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit slave address matched in the address byte.
- SYNC_STAGES, 2, flops in the clk_i input synchroniser for scl_i/sda_i (min 2).

Ports:
- clk_i  in  1  system clock, 100 MHz
- rstn  in  1  asynchronous, active-low reset
- sample_en  in  1  one-clk_i-cycle pulse at 1 MHz (10x SCL); all protocol logic advances only on this strobe
- scl_i  in  1  raw SCL pin
- sda_i  in  1  raw SDA pin
- sda_oe  out  1  1 = pull SDA low (ACK); 0 = release
- rx_data  out  8  received data byte
- rx_valid  out  1  rx_data valid; held until accepted
- rx_ready  in  1  consumer accepts when rx_valid&&rx_ready
- start_det  out  1  one-cycle pulse on START/repeated START
- stop_det  out  1  one-cycle pulse on STOP
- addr_hit  out  1  high from address ACK until STOP/next START
- busy  out  1  high between START and STOP
- rx_ovf  out  1  one-cycle pulse when a byte is dropped because rx_valid was still high

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, start_det=0, stop_det=0, addr_hit=0, busy=0, rx_ovf=0; state=IDLE; filtered SCL/SDA=1.
- Synchroniser runs every clk_i cycle. Filtered SCL/SDA and their previous values update only when sample_en=1.
- Edge events are evaluated at a sample_en:
  - SCL rise/fall: filtered change.
  - START: SDA 1->0 while SCL=1 in both the previous and current sample.
  - STOP: SDA 0->1 while SCL=1 in both the previous and current sample.
- START or STOP has priority over any bit event in the same sample.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first on SCL rise; bit counter 0..7.
  - ADDR_ACK: ack = (addr[7:1]==SLAVE_ADDR) && addr[0]==0.
  - DATA: shift 8 bits.
  - DATA_ACK: NACK if byte dropped, else ACK.
  - WAIT_STOP: ignore bus until START/STOP.
- Transitions:
  - START from any state -> ADDR; start_det pulse; busy=1; addr_hit=0; counter cleared.
  - STOP from any state -> IDLE; stop_det pulse; busy=0; addr_hit=0; sda_oe=0.
  - ADDR, 8th rise: wait for SCL fall, then -> ADDR_ACK. sda_oe=ack is driven at that SCL fall.
  - ADDR_ACK: at next SCL fall release sda_oe. Go to DATA (ack=1, addr_hit=1) or WAIT_STOP (ack=0).
  - DATA, 8th rise: byte complete.
    - If rx_valid=0: load rx_data, assert rx_valid in the clk_i cycle after that sample_en, drive ACK at the next SCL fall.
    - Else: drop byte, pulse rx_ovf, drive NACK (sda_oe stays 0), -> WAIT_STOP after the ACK clock.
  - DATA_ACK: release sda_oe at next SCL fall -> DATA.
- rx_valid clears the cycle after rx_valid&&rx_ready. rx_data is stable while rx_valid=1.
- sda_oe changes only in the clk_i cycle following a sample_en that saw an SCL fall. It never changes while SCL=1.
- Reset mid-transfer: everything returns to reset values immediately. The block stays in IDLE until the next START; a partial byte is discarded.
- sample_en held low: state frozen; synchroniser keeps running.

Optional Feature:
- I2C_GLITCH_FILTER_EN defined: each of SCL/SDA passes through a 3-sample majority filter at sample_en. The filtered value changes only when 2 of the last 3 samples agree, rejecting pulses shorter than 2 sample periods.
- Undefined: filtered value = synchroniser output captured at sample_en. Edge detection is one sample earlier; the state machine is unchanged.

Decomposition:
- Shared package i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP), I2C_ADDR_W=7, I2C_BYTE_W=8, and constant BIT_LAST=3'd7.
- One sub-module, i2c_line_filter: synchroniser plus optional majority filter plus edge outputs. Instantiated once per line (SCL, SDA).

Test Plan:
- Reset: hold rstn low mid-byte, release -> all outputs 0; no rx_valid until a fresh START.
- Write 0x84 (addr 0x42, W) then 0xA5, rx_ready=1 -> ACK on both 9th clocks, rx_data=0xA5, single rx_valid pulse, STOP -> stop_det pulse, busy=0.
- Address 0x43 W -> sda_oe never asserted, addr_hit=0; following data bytes ignored.
- Address 0x85 (0x42, R) -> NACK, WAIT_STOP; no rx_valid.
- rx_ready=0, write 0x11 then 0x22 -> 0x11 ACKed and held; 0x22 NACKed; rx_ovf pulses once; rx_data stays 0x11.
- Repeated START after 4 data bits -> start_det pulse, partial byte discarded; next 0x84 re-ACKed. With I2C_GLITCH_FILTER_EN, a 1-sample SCL low glitch during a data bit causes no extra bit.
